imem_fetch_server: RTL
======================

# imem_fetch_server

Instruction-memory responder serving the fetch requests issued by the pipeline's IF stage. It accepts one fetch address at a time over a valid/ready request channel and returns the instruction word (opcode + operand) over a valid/ready response channel after a programmable number of wait states. It also provides a program-loader write port and honours pipeline flushes on branch or halt redirects. It sits between `cpu_pipeline`'s fetch logic and the program image.

## Interface
- `ADDR_W`, 5: fetch/load address width; memory depth is 2**ADDR_W words.
- `DATA_W`, 8: instruction word width (opcode in the upper 3 bits, operand in the lower ADDR_W bits).
- `WAIT_CYCLES`, 1: wait states per fetch; legal range 0..7.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: fetch request from the IF stage.
- `req_ready` out 1: the server can accept a request this cycle.
- `req_addr` in ADDR_W: fetch address (the PC).
- `rsp_valid` out 1: the response word is valid.
- `rsp_ready` in 1: the IF stage consumes the response.
- `rsp_data` out DATA_W: instruction word.
- `rsp_addr` out ADDR_W: echo of the accepted address.
- `flush` in 1: drop any pending or presented fetch.
- `load_en` in 1: program-loader write strobe.
- `load_addr` in ADDR_W: loader address.
- `load_data` in DATA_W: loader data.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE) & ~`load_en` & ~`flush`. This is combinational.
- IDLE: on `req_valid & req_ready`, capture `req_addr` into `rsp_addr` and load the wait counter with WAIT_CYCLES.
  - If WAIT_CYCLES = 0, go directly to RESP and read memory.
  - Otherwise, go to WAIT.
- WAIT: decrement the counter each cycle. When the counter reaches 1, read memory into `rsp_data` and go to RESP.
- RESP: hold `rsp_valid` = 1, with `rsp_data` and `rsp_addr` stable, until `rsp_ready`. On the handshake, go to IDLE.
- There is never more than one fetch outstanding. A new request is only accepted in IDLE, the cycle after the response handshake.
- Loader:
  - When `load_en` = 1, the array is written at the clock edge.
  - A load is legal in any state.
  - `rsp_data` is registered at the read edge, so a later write to the same address does not alter a response already presented.
  - If a write and a read of the same address occur on the same edge, the read returns the old word.
- `flush`: from any state, go to IDLE at the next edge and clear `rsp_valid`. A request presented in the same cycle as `flush` is not accepted. Flush has priority over the `rsp_ready` handshake.
- Memory array is not reset; its contents survive `rst`.
- Out-of-range addresses cannot occur (depth = 2**ADDR_W).

## Timing
- Reset values (applied asynchronously on `rst` = 0, held while low):
  - state IDLE, counter 0.
  - `rsp_valid` 0, `rsp_data` 0, `rsp_addr` 0, `busy` 0.
  - `req_ready` is 1 once `rst` = 1 (when `load_en` and `flush` are low).
- Latency: request accepted at edge k → `rsp_valid` high in the cycle after edge k + WAIT_CYCLES.
  - WAIT_CYCLES = 0 gives one-cycle latency.
- Throughput: one fetch per (WAIT_CYCLES + 2) cycles when `rsp_ready` is tied high.
- Backpressure: `rsp_valid` stays high indefinitely while `rsp_ready` = 0, and `rsp_data` holds.
- Reset asserted mid-fetch aborts the fetch immediately. No response is produced after release.
- `busy` is registered and matches state ≠ IDLE.

## Structure
- Shared package `cpu_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults,
  - the opcode field position constants,
  - the `fetch_state_t` enum (IDLE/WAIT/RESP).
- Sub-module `imem_array`: 2**ADDR_W × DATA_W storage with one synchronous write port and one combinational read port, no reset. The FSM, counter and output registers stay in `imem_fetch_server`.

## Test plan
- **Load and fetch:** load addr 0..3 with 8'h21, 8'h42, 8'h63, 8'hE0; WAIT_CYCLES = 1; request addr 2 with `rsp_ready` = 1 → `rsp_valid` rises 2 cycles after acceptance with `rsp_data` = 8'h63, `rsp_addr` = 2. `busy` is high for 2 cycles.
- **Backpressure:** request addr 1, hold `rsp_ready` = 0 for 5 cycles → `rsp_valid`/`rsp_data` = 8'h42 stable. `req_ready` is 0 throughout. The handshake on cycle 6 returns to IDLE.
- **Flush:** request addr 3, assert `flush` during WAIT → `rsp_valid` never rises, state is IDLE next cycle. A `req_valid` held during the flush cycle is not accepted.
- **Load collision:** request addr 0, then write 8'hFF to addr 0 during RESP → response still 8'h21. The next fetch of addr 0 returns 8'hFF. `load_en` high forces `req_ready` = 0.
- **Reset mid-operation:** pull `rst` low during WAIT → all outputs are at reset values immediately. After release, fetch addr 3 returns 8'hE0 (memory preserved).
- **WAIT_CYCLES = 0 build:** back-to-back fetches of addr 0..3 with `rsp_ready` = 1 → each response arrives 1 cycle after acceptance, one fetch every 2 cycles, data 21/42/63/E0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: instruction word geometry and the fetch-server state encoding.
// Defaults here are overridable by the modules' own parameters.
package cpu_pkg;

  localparam int ADDR_W_DFLT = 5;
  localparam int DATA_W_DFLT = 8;

  localparam int OPC_W   = 3;
  localparam int OPC_MSB = DATA_W_DFLT - 1;
  localparam int OPC_LSB = DATA_W_DFLT - OPC_W;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [DATA_W_DFLT-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program storage: one synchronous write port, one combinational read port, no reset.
// A write and a read of the same word on one edge see the old contents at the read side.
module imem_array #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_fetch_server.sv
// Single-outstanding instruction fetch responder; response valid WAIT_CYCLES+1 cycles after accept.
// Response holds until rsp_ready; no new request accepted until the response handshake completes.
module imem_fetch_server
  import cpu_pkg::*;
#(
  parameter int          ADDR_W      = ADDR_W_DFLT,
  parameter int          DATA_W      = DATA_W_DFLT,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  fetch_state_t      state;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign req_ready = (state == IDLE) & ~load_en & ~flush;

  // In IDLE the only possible read is the zero-wait fetch of the incoming address.
  assign rd_addr = (state == IDLE) ? req_addr : rsp_addr;

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            rsp_addr <= req_addr;
            cnt      <= WAIT_INIT;
            busy     <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state     <= RESP;
              rsp_data  <= rd_data;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= RESP;
            rsp_data  <= rd_data;
            rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
